// File: rtl/jk_mod_counter_if.sv
// jk_mod_counter_if: counter bus; control in (en, up, load, din), state out (q, q_bar, tc, wrap, load_err)
interface jk_mod_counter_if #(parameter int WIDTH = 4);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             tc;
  logic             wrap;
  logic             load_err;
  modport master(output en, up, load, din, input q, q_bar, tc, wrap, load_err);
  modport slave(input en, up, load, din, output q, q_bar, tc, wrap, load_err);
endinterface

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MOD up/down counter on JK cells; clk, rst (async active-low), bus.slave carries en/up/load/din in and q/q_bar/tc/wrap/load_err out
module jk_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input logic             clk,
  input logic             rst,
  jk_mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MODV = (WIDTH + 1)'(MOD);
  logic [WIDTH-1:0] r_q, w_j, w_k, w_tgt, w_tog;
  logic             r_wrap, r_load_err;
  logic             w_tc, w_force, w_din_ok, w_illegal;
  always_comb begin
    w_din_ok  = {1'b0, bus.din} < MODV;
    w_illegal = {1'b0, r_q} >= MODV;
    w_tc      = bus.en & ~bus.load & (bus.up ? r_q == MAXV : r_q == '0);
    for (int i = 0; i < WIDTH; i++) begin
      w_tog[i] = bus.up ? &(r_q | ~WIDTH'((1 << i) - 1)) : &(~r_q | ~WIDTH'((1 << i) - 1));
    end
    w_force = bus.load | (bus.en & (w_illegal | w_tc));
    w_tgt   = bus.load ? (w_din_ok ? bus.din : '0) : (w_tc & ~bus.up) ? MAXV : '0;
    w_j     = w_force ? w_tgt : bus.en ? w_tog : '0;
    w_k     = w_force ? ~w_tgt : bus.en ? w_tog : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q        <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_q        <= (w_j & ~r_q) | (~w_k & r_q);
      r_wrap     <= w_tc;
      r_load_err <= bus.load & ~w_din_ok;
    end
  end
  assign bus.q        = r_q;
  assign bus.q_bar    = ~r_q;
  assign bus.tc       = w_tc;
  assign bus.wrap     = r_wrap;
  assign bus.load_err = r_load_err;
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: directed scoreboard bench for a single digit and a two-digit cascade
module tb_jk_mod_counter;
  localparam int M = 10;
  logic clk = 1'b0;
  logic rst = 1'b0;
  jk_mod_counter_if #(.WIDTH(4)) b0 ();
  jk_mod_counter_if #(.WIDTH(4)) b1 ();
  jk_mod_counter #(.WIDTH(4), .MOD(M)) u0 (.clk(clk), .rst(rst), .bus(b0));
  jk_mod_counter #(.WIDTH(4), .MOD(M)) u1 (.clk(clk), .rst(rst), .bus(b1));
  assign b1.en   = b0.tc;
  assign b1.up   = b0.up;
  assign b1.load = b0.load;
  assign b1.din  = '0;
  always #5 clk = ~clk;
  typedef struct {int q; int w; int e; int q1; int w1;} exp_t;
  exp_t sb[$];
  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;
  int mq = 0;
  int m1 = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    n_tot++;
    assert (obs === ex) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, ex);
    end
  endtask
  function automatic void nxt(input int q, en, up, ld, din, output int nq, w, e);
    nq = q; w = 0; e = 0;
    if (ld != 0) begin
      if (din < M) nq = din;
      else begin nq = 0; e = 1; end
    end else if (en != 0) begin
      if (up != 0) begin
        if (q == M - 1) begin nq = 0; w = 1; end
        else nq = q + 1;
      end else begin
        if (q == 0) begin nq = M - 1; w = 1; end
        else nq = q - 1;
      end
    end
  endfunction
  task automatic step(input int en, up, ld, din);
    exp_t x;
    int tc0, d;
    @(negedge clk);
    b0.en = en[0]; b0.up = up[0]; b0.load = ld[0]; b0.din = din[3:0];
    #1;
    tc0 = (en != 0 && ld == 0 && ((up != 0 && mq == M - 1) || (up == 0 && mq == 0))) ? 1 : 0;
    chk("tc", b0.tc, tc0);
    nxt(mq, en, up, ld, din, x.q, x.w, x.e);
    nxt(m1, tc0, up, ld, 0, x.q1, x.w1, d);
    sb.push_back(x);
    mq = x.q; m1 = x.q1;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("q", b0.q, x.q);
    chk("q_bar", b0.q_bar, (~x.q) & 15);
    chk("wrap", b0.wrap, x.w);
    chk("load_err", b0.load_err, x.e);
    chk("d1_q", b1.q, x.q1);
    chk("d1_wrap", b1.wrap, x.w1);
  endtask
  initial begin
    b0.en = 1'b0; b0.up = 1'b1; b0.load = 1'b0; b0.din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", b0.q, 0);
    chk("rst_q_bar", b0.q_bar, 15);
    chk("rst_wrap", b0.wrap, 0);
    chk("rst_load_err", b0.load_err, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (7) step(1, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_q", b0.q, 0);
    chk("arst_q_bar", b0.q_bar, 15);
    chk("arst_wrap", b0.wrap, 0);
    mq = 0; m1 = 0;
    b0.en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_hold_q", b0.q, 0);
    end
    @(negedge clk);
    b0.en = 1'b0;
    rst = 1'b1;
    repeat (10) step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 1, 6);
    step(1, 1, 1, 12);
    step(0, 1, 0, 0);
    step(0, 0, 1, 4);
    repeat (5) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 15);
    step(0, 0, 1, 9);
    step(1, 1, 0, 0);
    step(0, 0, 1, 10);
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    repeat (100) step(1, 1, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter whose state bits are JK toggle cells: per-bit J/K terms computed combinationally, next state Q+ = (J & ~Q) | (~K & Q).
- Sits directly downstream of the team's JK flip-flop stage and consumes that cell as its storage primitive.
- Provides parallel load, count enable and a cascade terminal-count output, so multi-digit counters (BCD digits, timers) are chained instances.

Parameters:
- WIDTH, 4, counter width in bits; must satisfy 2^WIDTH >= MOD.
- MOD, 10, count modulus; legal states 0..MOD-1; MOD >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  in  1  synchronous parallel load; priority over en.
- din  in  WIDTH  load value.
- q  out  WIDTH  count state.
- q_bar  out  WIDTH  bitwise complement of q.
- tc  out  1  combinational terminal count: en & ~load & ((up & q==MOD-1) | (~up & q==0)).
- wrap  out  1  registered one-cycle pulse, set on the edge where the count wraps.
- load_err  out  1  registered one-cycle pulse, set on the edge where an illegal din (>= MOD) is loaded.

Behaviour:
- Reset: rst low forces q=0, wrap=0 and load_err=0 immediately, independent of clk. q_bar=all ones. All held while rst=0.
- Reset deassertion: first active edge is the first rising clk edge with rst=1. Reset asserted mid-count aborts the count with no wrap pulse.
- Per-edge priority: load > en > hold.
- load=1:
  - din < MOD: q <= din, load_err <= 0.
  - din >= MOD: q <= 0, load_err <= 1.
  - wrap <= 0 in both cases; en and up are ignored.
- load=0, en=1, up=1:
  - q < MOD-1: q <= q+1.
  - q = MOD-1: q <= 0, wrap <= 1.
- load=0, en=1, up=0:
  - q > 0: q <= q-1.
  - q = 0: q <= MOD-1, wrap <= 1.
- load=0, en=0: q holds; wrap <= 0; load_err <= 0.
- wrap and load_err are single-cycle pulses; they return to 0 on the next edge unless re-triggered.
- Latency: every q change is visible one clk edge after the qualifying inputs; tc has zero latency, for cascading into the next stage's en.
- JK derivation, per bit i:
  - Normal count: J=K=toggle_i, where toggle_i is the AND of lower bits (up) or of lower inverted bits (down).
  - Wrap: J=0/K=1 forces a bit to 0; J=1/K=0 forces a bit to 1, building 0 or MOD-1.
  - Load: J=din_i, K=~din_i.
  - Hold: J=K=0.
- Illegal state (q >= MOD): unreachable after reset. If forced, the next counting edge in either direction loads 0 with no wrap pulse.
- MOD = 2^WIDTH: wrap detection still uses MOD-1 and 0. No special case.

Test Plan:
- Reset: rst=0 mid-count at q=7 -> q=0, q_bar=4'hF, wrap=0 before the next clk edge; hold rst=0 for 3 edges -> q stays 0.
- Up count: en=1, up=1 for 10 edges from 0 -> q=1..9 then 0; wrap=1 only on the edge reaching 0; tc=1 only while q=9.
- Down count: en=1, up=0 from q=0 -> q=9, wrap=1 on that edge, then 8,7...; tc=1 only while q=0.
- Load: load=1, din=6 with en=1, up=1 -> q=6 (no increment), load_err=0; load=1, din=12 -> q=0, load_err=1 for exactly one cycle.
- Hold and direction change: en=0 at q=4 for 5 edges -> q=4, wrap=0; then en=1 with up toggling each edge -> q=5,4,5,4.
- Cascade: two instances, tc of digit0 driving en of digit1, up=1, 100 edges from 00 -> output 99 then 00; digit1 wrap=1 on the final edge only.
